// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the fetch port, load/store port, memory bus and
// timeout flag of mem_arbiter into one bundle.
//   slave  : the arbiter's view (takes core requests and memory responses)
//   master : the environment's view (core + memory drive the arbiter)
interface mem_arbiter_if;
    // instruction-fetch port
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    // load/store port
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    // memory bus
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    // sticky timeout flag
    logic        err_timeout;

    modport slave (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata,
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata,
        output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        input  mem_reqReady, mem_respValid, mem_rdata,
        output err_timeout
    );

    modport master (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata,
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata,
        input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        output mem_reqReady, mem_respValid, mem_rdata,
        input  err_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the core's fetch (ifu) and load/store (lsu) ports
// onto one memory bus. Request pulses are latched, LSU has fixed priority,
// the memory handshake is request/ready followed by a response pulse, and
// the result returns to the originating port as a one-cycle pulse. A WAIT
// timer forces an ERR_DATA response if memory stays silent.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (ifu_*, lsu_*, mem_*, err_timeout)
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state, next_state;
    logic        gnt_lsu;
    logic        ifu_pend, lsu_pend;
    logic [31:0] ifu_addr_q;
    logic [31:0] lsu_addr_q, lsu_wdata_q;
    logic [1:0]  lsu_size_q;
    logic        lsu_wen_q;
    logic [3:0]  lsu_wmask_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [1:0]  mem_size_q;
    logic        mem_wen_q;
    logic [3:0]  mem_wmask_q;
    logic [31:0] timer;
    logic [31:0] ifu_rdata_q, lsu_rdata_q;
    logic        err_q;
    logic        take_lsu, take_ifu, timeout_hit;
    logic        ifu_busy, lsu_busy;
    logic [31:0] resp_data;

    // a port is busy while its own transaction is anywhere past IDLE
    assign ifu_busy  = (state != IDLE) && !gnt_lsu;
    assign lsu_busy  = (state != IDLE) && gnt_lsu;
    assign resp_data = bus.mem_respValid ? bus.mem_rdata : ERR_DATA;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        take_lsu    = 1'b0;
        take_ifu    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (lsu_pend || bus.lsu_reqValid) begin
                    take_lsu   = 1'b1;
                    next_state = REQ;
                end else if (ifu_pend || bus.ifu_reqValid) begin
                    take_ifu   = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (bus.mem_reqReady) next_state = WAIT;
            end
            WAIT: begin
                // a response in the final timer cycle beats the timeout
                if (bus.mem_respValid) begin
                    next_state = RESP;
                end else if ((TIMEOUT != 0) && (timer == TMO_LAST)) begin
                    timeout_hit = 1'b1;
                    next_state  = RESP;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_lsu     <= 1'b0;
            ifu_pend    <= 1'b0;
            lsu_pend    <= 1'b0;
            ifu_addr_q  <= '0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
            lsu_size_q  <= '0;
            lsu_wen_q   <= 1'b0;
            lsu_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= '0;
            timer       <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            // capture; a request granted in this same cycle bypasses the pend bit
            if (bus.ifu_reqValid && !ifu_pend && !ifu_busy && !take_ifu) begin
                ifu_pend   <= 1'b1;
                ifu_addr_q <= bus.ifu_addr;
            end
            if (bus.lsu_reqValid && !lsu_pend && !lsu_busy && !take_lsu) begin
                lsu_pend    <= 1'b1;
                lsu_addr_q  <= bus.lsu_addr;
                lsu_size_q  <= bus.lsu_size;
                lsu_wen_q   <= bus.lsu_wen;
                lsu_wdata_q <= bus.lsu_wdata;
                lsu_wmask_q <= bus.lsu_wmask;
            end

            if (take_lsu) begin
                gnt_lsu  <= 1'b1;
                lsu_pend <= 1'b0;
                if (lsu_pend) begin
                    mem_addr_q  <= lsu_addr_q;
                    mem_size_q  <= lsu_size_q;
                    mem_wen_q   <= lsu_wen_q;
                    mem_wdata_q <= lsu_wdata_q;
                    mem_wmask_q <= lsu_wmask_q;
                end else begin
                    mem_addr_q  <= bus.lsu_addr;
                    mem_size_q  <= bus.lsu_size;
                    mem_wen_q   <= bus.lsu_wen;
                    mem_wdata_q <= bus.lsu_wdata;
                    mem_wmask_q <= bus.lsu_wmask;
                end
            end else if (take_ifu) begin
                gnt_lsu     <= 1'b0;
                ifu_pend    <= 1'b0;
                mem_addr_q  <= ifu_pend ? ifu_addr_q : bus.ifu_addr;
                mem_size_q  <= 2'd2;
                mem_wen_q   <= 1'b0;
                mem_wdata_q <= '0;
                mem_wmask_q <= '0;
            end

            // held at zero in REQ so it starts from 0 on entry to WAIT
            if (state == REQ) begin
                timer <= '0;
            end else if ((state == WAIT) && (timer != '1)) begin
                timer <= timer + 32'd1;
            end

            if ((state == WAIT) && (next_state == RESP)) begin
                if (gnt_lsu) lsu_rdata_q <= resp_data;
                else         ifu_rdata_q <= resp_data;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_reqValid  = (state == REQ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_size      = mem_size_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.ifu_respValid = (state == RESP) && !gnt_lsu;
    assign bus.lsu_respValid = (state == RESP) && gnt_lsu;
    assign bus.ifu_rdata     = ifu_rdata_q;
    assign bus.lsu_rdata     = lsu_rdata_q;
    assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized checks of mem_arbiter with TIMEOUT=8.
// The bench plays core and memory; a queue of expected transactions in
// service order plus the latency/timeout rules predict every observation.
module tb_mem_arbiter;
    localparam int TMO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        bit          is_lsu;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    txn_t exp_q[$];
    logic [31:0] last_ifu, last_lsu;
    logic err_exp;

    mem_arbiter_if bus_if();

    mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk_lsu(input logic [31:0] a, input logic [1:0] s,
                                    input logic w, input logic [31:0] d, input logic [3:0] m);
        txn_t t;
        t.is_lsu = 1'b1; t.addr = a; t.size = s; t.wen = w; t.wdata = d; t.wmask = m;
        return t;
    endfunction

    task automatic chk_fields(input txn_t t);
        chk("mem_addr", bus_if.mem_addr, t.addr);
        chk("mem_ctl", {25'b0, bus_if.mem_wen, bus_if.mem_size, bus_if.mem_wmask},
            {25'b0, t.wen, t.size, t.wmask});
        chk("mem_wdata", bus_if.mem_wdata, t.wdata);
    endtask

    // Drive request pulse(s) during the current (IDLE) cycle, then scramble
    // the fields so a pending request can only be served from captured values.
    task automatic issue(input bit do_ifu, input bit do_lsu, input logic [31:0] ia, input txn_t l);
        txn_t f;
        if (do_ifu) begin bus_if.ifu_reqValid = 1'b1; bus_if.ifu_addr = ia; end
        if (do_lsu) begin
            bus_if.lsu_reqValid = 1'b1; bus_if.lsu_addr = l.addr; bus_if.lsu_size = l.size;
            bus_if.lsu_wen = l.wen; bus_if.lsu_wdata = l.wdata; bus_if.lsu_wmask = l.wmask;
        end
        tick();
        bus_if.ifu_reqValid = 1'b0;
        bus_if.lsu_reqValid = 1'b0;
        bus_if.ifu_addr  = $urandom;
        bus_if.lsu_addr  = $urandom;
        bus_if.lsu_wdata = $urandom;
        bus_if.lsu_wmask = 4'($urandom);
        if (do_lsu) exp_q.push_back(l);
        if (do_ifu) begin
            f.is_lsu = 1'b0; f.addr = ia; f.size = 2'd2; f.wen = 1'b0; f.wdata = '0; f.wmask = '0;
            exp_q.push_back(f);
        end
    endtask

    // Act as memory for the next expected transaction: stall rdy_dly cycles,
    // answer after lat WAIT cycles (or stay silent), then check the response.
    task automatic serve(input int exp_wait, input int rdy_dly, input int lat,
                         input bit respond, input logic [31:0] d_in);
        txn_t t;
        int waited;
        int n;
        bit real_resp;
        logic [31:0] d;
        if (exp_q.size() == 0) begin chk("exp_queue_empty", 32'd1, 32'd0); return; end
        t = exp_q.pop_front();
        waited = 0;
        while (bus_if.mem_reqValid !== 1'b1 && waited < 40) begin tick(); waited++; end
        chk("req_wait", 32'(waited), 32'(exp_wait));
        if (bus_if.mem_reqValid !== 1'b1) return;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("reqValid_held", {31'b0, bus_if.mem_reqValid}, 32'd1);
            chk_fields(t);
            bus_if.mem_reqReady = (i == rdy_dly);
            tick();
        end
        bus_if.mem_reqReady = 1'b0;
        chk("reqValid_drop", {31'b0, bus_if.mem_reqValid}, 32'd0);
        real_resp = respond && (lat < TMO);
        n = real_resp ? lat : TMO - 1;
        for (int i = 0; i < n; i++) begin
            chk("no_early_resp", {30'b0, bus_if.ifu_respValid, bus_if.lsu_respValid}, 32'd0);
            tick();
        end
        d = real_resp ? d_in : ERR;
        if (real_resp) begin bus_if.mem_respValid = 1'b1; bus_if.mem_rdata = d_in; end
        else err_exp = 1'b1;
        tick();
        bus_if.mem_respValid = 1'b0;
        bus_if.mem_rdata = $urandom;
        if (t.is_lsu) last_lsu = d; else last_ifu = d;
        chk("resp_pulse", {30'b0, bus_if.ifu_respValid, bus_if.lsu_respValid},
            t.is_lsu ? 32'd1 : 32'd2);
        chk("ifu_rdata", bus_if.ifu_rdata, last_ifu);
        chk("lsu_rdata", bus_if.lsu_rdata, last_lsu);
        chk("err_timeout", {31'b0, bus_if.err_timeout}, {31'b0, err_exp});
        tick();
        chk("resp_one_cycle", {30'b0, bus_if.ifu_respValid, bus_if.lsu_respValid}, 32'd0);
    endtask

    initial begin
        txn_t l;
        tests = 0; fails = 0; cyc = 0;
        last_ifu = '0; last_lsu = '0; err_exp = 1'b0;
        bus_if.ifu_reqValid = 1'b0; bus_if.ifu_addr = '0;
        bus_if.lsu_reqValid = 1'b0; bus_if.lsu_addr = '0; bus_if.lsu_size = '0;
        bus_if.lsu_wen = 1'b0; bus_if.lsu_wdata = '0; bus_if.lsu_wmask = '0;
        bus_if.mem_reqReady = 1'b0; bus_if.mem_respValid = 1'b0; bus_if.mem_rdata = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("reset_ctl", {28'b0, bus_if.mem_reqValid, bus_if.ifu_respValid,
                          bus_if.lsu_respValid, bus_if.err_timeout}, 32'd0);
        chk("reset_addr", bus_if.mem_addr, 32'd0);
        chk("reset_rdata", bus_if.ifu_rdata | bus_if.lsu_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // fetch, L=2: response 5 cycles after the request
        l = mk_lsu('0, '0, 1'b0, '0, '0);
        issue(1'b1, 1'b0, 32'h3000_0000, l);
        serve(0, 0, 2, 1'b1, 32'h0010_0093);

        // store with a 3-cycle ready stall
        issue(1'b0, 1'b1, '0, mk_lsu(32'h8000_0004, 2'd1, 1'b1, 32'hA5A5_1234, 4'b0011));
        serve(0, 3, 1, 1'b1, 32'h1234_5678);

        // collision: LSU first, IFU granted in the IDLE cycle after LSU's RESP
        issue(1'b1, 1'b1, 32'h0000_0100, mk_lsu(32'h0000_0200, 2'd2, 1'b0, '0, '0));
        serve(0, 0, 0, 1'b1, 32'hCAFE_0001);
        serve(1, 0, 0, 1'b1, 32'hCAFE_0002);

        // response in the last timeout cycle wins
        issue(1'b1, 1'b0, 32'h0000_0040, l);
        serve(0, 0, TMO - 1, 1'b1, 32'h7777_0007);

        // silent memory -> forced error, flag stays set afterwards
        issue(1'b1, 1'b0, 32'h0000_0080, l);
        serve(0, 0, TMO, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h0000_0084, l);
        serve(0, 1, 0, 1'b1, 32'h0BAD_F00D);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int p;
            p = $urandom_range(0, 2);
            l = mk_lsu($urandom, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, 4'($urandom));
            issue(p != 1, p != 0, $urandom, l);
            serve(0, $urandom_range(0, 3), $urandom_range(0, TMO + 1), 1'b1, $urandom);
            if (p == 2) serve(1, $urandom_range(0, 3), $urandom_range(0, TMO + 1), 1'b1, $urandom);
        end

        // asynchronous reset while in WAIT
        issue(1'b1, 1'b0, 32'h0000_0500, l);
        bus_if.mem_reqReady = 1'b1;
        tick();
        bus_if.mem_reqReady = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {28'b0, bus_if.mem_reqValid, bus_if.ifu_respValid,
                              bus_if.lsu_respValid, bus_if.err_timeout}, 32'd0);
        chk("async_rst_addr", bus_if.mem_addr, 32'd0);
        chk("async_rst_rdata", bus_if.ifu_rdata | bus_if.lsu_rdata, 32'd0);
        exp_q.delete();
        last_ifu = '0; last_lsu = '0; err_exp = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus_if.mem_respValid = 1'b1;
        bus_if.mem_rdata = 32'h5555_AAAA;
        tick();
        bus_if.mem_respValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_resp_ignored", {29'b0, bus_if.mem_reqValid, bus_if.ifu_respValid,
                                      bus_if.lsu_respValid}, 32'd0);
            tick();
        end
        issue(1'b1, 1'b0, 32'h0000_0600, l);
        serve(0, 0, 1, 1'b1, 32'h600D_0600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
